decode_ctrl_stage: RTL and testbench
====================================

// Module: decode_ctrl_stage
// PURPOSE
// - Registered main-decode stage of the pipelined core: decodes opcode/funct3/funct7 into the control bundle and
//   holds it in a one-entry ID/EX control register with valid/ready handshake, stall and flush.
// - Adds RV64 word-ops, an M-extension flag, illegal-opcode detection and a halt-drain FSM.
// - Sits between the IF/ID register and the execute stage; the hazard unit drives flush and out_ready.
// PARAMETERS
// - XLEN            32  32 or 64; 64 enables OP-IMM-32/OP-32 (0011011/0111011) and LD/LWU/SD sizes
// - M_EXT           1   1: OP/OP-32 with funct7=0000001 sets mdu_op; 0: such encodings are illegal
// - DRAIN_CYCLES    3   cycles to wait after a halting instruction leaves before hlt asserts (1..15)
// - HALT_ON_ILLEGAL 1   1: an illegal opcode starts the halt-drain exactly as SYSTEM does
// PORTS
// - clk           in   1  clock, all state on rising edge
// - rst_n         in   1  synchronous reset, active low
// - in_valid      in   1  IF/ID holds a valid instruction
// - in_ready      out  1  stage accepts instr this cycle
// - instr         in   32 instruction word
// - flush         in   1  squash the held bundle (branch/jump resolved in EX)
// - out_ready     in   1  EX consumes the bundle this cycle (0 = stall)
// - out_valid     out  1  bundle below is valid
// - memtoreg, memwrite, branch, regwrite, jump, jumpsrc, alusrc_a_zero  out  1 each  control bits
// - memsize       out  3  funct3 for LOAD/STORE, else 3'b000
// - alusrc        out  2  ALU B-source select
// - word_op       out  1  RV64 32-bit op (0 when XLEN=32)
// - mdu_op        out  1  multiply/divide op
// - illegal       out  1  bundle is an illegal instruction
// - hlt           out  1  core halted (sticky)
// BEHAVIOUR
// - Reset: out_valid=0, every bundle bit 0, memsize=0, alusrc=ALU_SRC_REG, hlt=0, FSM=RUN, drain counter=0.
// - Decode is pure combinational logic; every unset field is 0. No latches and no X on any output.
// - Decode table:
//   BRANCH: branch, alusrc=REG. JAL/JALR: jump, regwrite, alusrc_a_zero, alusrc=NPC, jumpsrc=(JALR).
//   LOAD: regwrite, memtoreg, alusrc=IMM. STORE: memwrite, alusrc=IMM.
//   LUI: alusrc_a_zero, alusrc=IMM, regwrite. OP-IMM: alusrc=IMM, regwrite. AUIPC: alusrc=PC, alusrc_a_zero, regwrite.
//   OP: alusrc=REG, regwrite. SYSTEM (funct3=0): halting instruction, no other bits set.
// - Legality: memsize values 011/110 are legal only when XLEN=64; other unlisted opcodes/funct3 set illegal=1
//   with all write enables 0.
// - Handshake: in_ready = (state==RUN) & (~out_valid | out_ready) & ~flush.
//   Accept = in_valid & in_ready -> the bundle loads next edge and out_valid=1.
//   If out_valid & out_ready & ~accept, out_valid clears. When out_ready=0 the bundle holds stable.
// - Flush has priority over everything: next cycle out_valid=0 and no instruction is accepted that cycle.
// - Halt FSM:
//   RUN -> DRAIN when a halting instruction (SYSTEM, or illegal with HALT_ON_ILLEGAL) is accepted;
//   the counter loads DRAIN_CYCLES and the halting bundle itself is still presented.
//   DRAIN: in_ready=0. The counter decrements only after the halting bundle is consumed (out_valid=0).
//   Counter at 0 -> HALTED with hlt=1. Flush while in DRAIN -> RUN, counter cleared (the halting instruction was squashed).
//   HALTED: in_ready=0, out_valid=0, and the state is held until rst_n=0.
// - Reset mid-drain or while HALTED returns the block to RUN with all outputs at their reset values.
// STRUCTURE
// - Shared package riscv_pkg: OPC_* opcodes (incl. OPC_OP_IMM32/OPC_OP32), ALU_SRC_{REG,IMM,PC,NPC}=0..3,
//   FUNCT7_MULDIV, MEMSIZE_* codes, the ctrl_bundle_t packed struct, and the halt_state_t enum {RUN,DRAIN,HALTED}.
// - One sub-module: ctrl_decoder, purely combinational (opc, funct3, funct7 -> ctrl_bundle_t). This file holds the
//   register, handshake and FSM.
// TESTING
// - Reset: rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, hlt=0, all bundle bits 0.
// - Stream add, lw x1,4(x0), sw, jalr, with out_ready=1 -> each bundle one cycle after accept.
//   lw gives memsize=010, memtoreg=1; jalr gives jumpsrc=1, alusrc=3.
// - Stall: out_ready=0 for 3 cycles while holding beq -> in_ready=0 and the bundle stays stable.
//   Set out_ready=1 -> the next instruction is accepted the same cycle.
// - Flush with in_valid=1 -> out_valid=0 next cycle and the instruction is not accepted.
//   Flush in DRAIN -> RUN, and hlt stays 0.
// - ecall (0x00000073), DRAIN_CYCLES=3 -> the bundle is consumed, then hlt=1 exactly 3 cycles later.
//   in_ready stays 0 until reset.
// - XLEN=32: opcode 0111011 -> illegal=1 and drain starts. XLEN=64: addw -> word_op=1.
//   M_EXT=1: mul -> mdu_op=1, regwrite=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants, the control bundle layout and the halt FSM states.
package riscv_pkg;

    // Major opcodes
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // ALU B-operand source select
    localparam logic [1:0] ALU_SRC_REG = 2'd0;
    localparam logic [1:0] ALU_SRC_IMM = 2'd1;
    localparam logic [1:0] ALU_SRC_PC  = 2'd2;
    localparam logic [1:0] ALU_SRC_NPC = 2'd3;

    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // Load/store access sizes (funct3 encodings)
    localparam logic [2:0] MEMSIZE_B  = 3'b000;
    localparam logic [2:0] MEMSIZE_H  = 3'b001;
    localparam logic [2:0] MEMSIZE_W  = 3'b010;
    localparam logic [2:0] MEMSIZE_D  = 3'b011;
    localparam logic [2:0] MEMSIZE_BU = 3'b100;
    localparam logic [2:0] MEMSIZE_HU = 3'b101;
    localparam logic [2:0] MEMSIZE_WU = 3'b110;

    typedef struct packed {
        logic       memtoreg;
        logic       memwrite;
        logic       branch;
        logic       regwrite;
        logic       jump;
        logic       jumpsrc;
        logic       alusrc_a_zero;
        logic [2:0] memsize;
        logic [1:0] alusrc;
        logic       word_op;
        logic       mdu_op;
        logic       illegal;
        logic       system;   // halting instruction (ecall/ebreak class)
    } ctrl_bundle_t;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} halt_state_t;

endpackage

// File: rtl/decode_ctrl_stage_if.sv
// Handshake and control-bundle signals between IF/ID, the decode stage and EX.
interface decode_ctrl_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic        memtoreg;
    logic        memwrite;
    logic        branch;
    logic        regwrite;
    logic        jump;
    logic        jumpsrc;
    logic        alusrc_a_zero;
    logic [2:0]  memsize;
    logic [1:0]  alusrc;
    logic        word_op;
    logic        mdu_op;
    logic        illegal;
    logic        hlt;

    modport master (
        output in_valid, instr, flush, out_ready,
        input  in_ready, out_valid, memtoreg, memwrite, branch, regwrite, jump, jumpsrc,
               alusrc_a_zero, memsize, alusrc, word_op, mdu_op, illegal, hlt
    );

    modport slave (
        input  in_valid, instr, flush, out_ready,
        output in_ready, out_valid, memtoreg, memwrite, branch, regwrite, jump, jumpsrc,
               alusrc_a_zero, memsize, alusrc, word_op, mdu_op, illegal, hlt
    );
endinterface

// File: rtl/ctrl_decoder.sv
// Purely combinational main decoder: opcode/funct3/funct7 -> control bundle.
module ctrl_decoder
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned M_EXT = 1
) (
    input  logic [6:0]   opc,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    output ctrl_bundle_t ctrl
);

    localparam bit Rv64 = (XLEN == 64);
    localparam bit MExt = (M_EXT != 0);

    logic legal;

    // Decode table; anything not explicitly legal collapses to a bare illegal bundle.
    always_comb begin
        ctrl  = '0;
        legal = 1'b1;
        case (opc)
            OPC_BRANCH: begin
                ctrl.branch = 1'b1;
                ctrl.alusrc = ALU_SRC_REG;
                legal       = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OPC_JAL, OPC_JALR: begin
                ctrl.jump          = 1'b1;
                ctrl.regwrite      = 1'b1;
                ctrl.alusrc_a_zero = 1'b1;
                ctrl.alusrc        = ALU_SRC_NPC;
                ctrl.jumpsrc       = (opc == OPC_JALR);
                legal              = (opc == OPC_JAL) || (funct3 == 3'b000);
            end
            OPC_LOAD: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.alusrc   = ALU_SRC_IMM;
                ctrl.memsize  = funct3;
                case (funct3)
                    MEMSIZE_B, MEMSIZE_H, MEMSIZE_W, MEMSIZE_BU, MEMSIZE_HU: legal = 1'b1;
                    MEMSIZE_D, MEMSIZE_WU:                                   legal = Rv64;
                    default:                                                 legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                ctrl.memwrite = 1'b1;
                ctrl.alusrc   = ALU_SRC_IMM;
                ctrl.memsize  = funct3;
                case (funct3)
                    MEMSIZE_B, MEMSIZE_H, MEMSIZE_W: legal = 1'b1;
                    MEMSIZE_D:                       legal = Rv64;
                    default:                         legal = 1'b0;
                endcase
            end
            OPC_LUI: begin
                ctrl.alusrc_a_zero = 1'b1;
                ctrl.alusrc        = ALU_SRC_IMM;
                ctrl.regwrite      = 1'b1;
            end
            OPC_OP_IMM: begin
                ctrl.alusrc   = ALU_SRC_IMM;
                ctrl.regwrite = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl.alusrc        = ALU_SRC_PC;
                ctrl.alusrc_a_zero = 1'b1;
                ctrl.regwrite      = 1'b1;
            end
            OPC_OP: begin
                ctrl.alusrc   = ALU_SRC_REG;
                ctrl.regwrite = 1'b1;
                case (funct7)
                    FUNCT7_BASE:   legal = 1'b1;
                    FUNCT7_ALT:    legal = (funct3 == 3'b000) || (funct3 == 3'b101);
                    FUNCT7_MULDIV: begin
                        ctrl.mdu_op = 1'b1;
                        legal       = MExt;
                    end
                    default:       legal = 1'b0;
                endcase
            end
            OPC_OP_IMM32: begin
                ctrl.word_op  = 1'b1;
                ctrl.alusrc   = ALU_SRC_IMM;
                ctrl.regwrite = 1'b1;
                legal = Rv64 && ((funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b101));
            end
            OPC_OP32: begin
                ctrl.word_op  = 1'b1;
                ctrl.alusrc   = ALU_SRC_REG;
                ctrl.regwrite = 1'b1;
                case (funct7)
                    FUNCT7_BASE: legal = Rv64 && ((funct3 == 3'b000) || (funct3 == 3'b001) ||
                                                  (funct3 == 3'b101));
                    FUNCT7_ALT:  legal = Rv64 && ((funct3 == 3'b000) || (funct3 == 3'b101));
                    FUNCT7_MULDIV: begin
                        ctrl.mdu_op = 1'b1;
                        legal = Rv64 && MExt && (funct3 != 3'b001) && (funct3 != 3'b010) &&
                                (funct3 != 3'b011);
                    end
                    default:     legal = 1'b0;
                endcase
            end
            OPC_SYSTEM: begin
                ctrl.system = 1'b1;
                legal       = (funct3 == 3'b000);
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered decode stage: one-entry ID/EX control register with handshake, flush and
// a halt-drain FSM that stops the front end after a halting instruction leaves.
module decode_ctrl_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned M_EXT           = 1,
    parameter int unsigned DRAIN_CYCLES    = 3,
    parameter int unsigned HALT_ON_ILLEGAL = 1
) (
    input logic               clk,
    input logic               rst_n,
    decode_ctrl_stage_if.slave bus
);

    ctrl_bundle_t dec;
    ctrl_bundle_t bundle_q, bundle_d;
    halt_state_t  state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         out_valid_q, out_valid_d;
    logic         in_ready, accept, halting;
    logic         unused_bits;

    ctrl_decoder #(
        .XLEN  (XLEN),
        .M_EXT (M_EXT)
    ) u_ctrl_decoder (
        .opc    (bus.instr[6:0]),
        .funct3 (bus.instr[14:12]),
        .funct7 (bus.instr[31:25]),
        .ctrl   (dec)
    );

    // Register indices and immediates are consumed by other stages.
    assign unused_bits = ^{bus.instr[24:15], bus.instr[11:7], bundle_q.system};

    // Handshake: only accept in RUN, when the slot is free or draining, and never during flush.
    always_comb begin
        in_ready = (state_q == RUN) && (!out_valid_q || bus.out_ready) && !bus.flush;
        accept   = bus.in_valid && in_ready;
        halting  = dec.system || ((HALT_ON_ILLEGAL != 0) && dec.illegal);
    end

    // Next-state for the control register, valid flag and halt-drain FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;

        if (accept) begin
            bundle_d    = dec;
            out_valid_d = 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            RUN: begin
                if (accept && halting) begin
                    state_d = DRAIN;
                    cnt_d   = 4'(DRAIN_CYCLES);
                end
            end
            DRAIN: begin
                if (bus.flush) begin
                    // Halting instruction squashed: resume normal operation.
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (!out_valid_q) begin
                    // Countdown starts once EX has taken the halting bundle.
                    if (cnt_q <= 4'd1) begin
                        state_d = HALTED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            HALTED:  out_valid_d = 1'b0;
            default: state_d = RUN;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid_q;
    assign bus.memtoreg      = bundle_q.memtoreg;
    assign bus.memwrite      = bundle_q.memwrite;
    assign bus.branch        = bundle_q.branch;
    assign bus.regwrite      = bundle_q.regwrite;
    assign bus.jump          = bundle_q.jump;
    assign bus.jumpsrc       = bundle_q.jumpsrc;
    assign bus.alusrc_a_zero = bundle_q.alusrc_a_zero;
    assign bus.memsize       = bundle_q.memsize;
    assign bus.alusrc        = bundle_q.alusrc;
    assign bus.word_op       = bundle_q.word_op;
    assign bus.mdu_op        = bundle_q.mdu_op;
    assign bus.illegal       = bundle_q.illegal;
    assign bus.hlt           = (state_q == HALTED);

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage: an XLEN=32 instance for handshake/halt behaviour and
// an XLEN=64 instance for RV64-only encodings.
module tb_decode_ctrl_stage;

    logic clk = 1'b0;
    logic rst_n;
    logic rst64_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    decode_ctrl_stage_if bus32 ();
    decode_ctrl_stage_if bus64 ();

    decode_ctrl_stage #(
        .XLEN            (32),
        .M_EXT           (1),
        .DRAIN_CYCLES    (3),
        .HALT_ON_ILLEGAL (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus32)
    );

    decode_ctrl_stage #(
        .XLEN            (64),
        .M_EXT           (1),
        .DRAIN_CYCLES    (3),
        .HALT_ON_ILLEGAL (1)
    ) dut64 (
        .clk   (clk),
        .rst_n (rst64_n),
        .bus   (bus64)
    );

    // Bundle order: memtoreg memwrite branch regwrite jump jumpsrc a_zero memsize alusrc word mdu ill
    logic [14:0] obs32, obs64;
    assign obs32 = {bus32.memtoreg, bus32.memwrite, bus32.branch, bus32.regwrite, bus32.jump,
                    bus32.jumpsrc, bus32.alusrc_a_zero, bus32.memsize, bus32.alusrc,
                    bus32.word_op, bus32.mdu_op, bus32.illegal};
    assign obs64 = {bus64.memtoreg, bus64.memwrite, bus64.branch, bus64.regwrite, bus64.jump,
                    bus64.jumpsrc, bus64.alusrc_a_zero, bus64.memsize, bus64.alusrc,
                    bus64.word_op, bus64.mdu_op, bus64.illegal};

    function automatic logic [14:0] bv(input logic m2r, input logic mw, input logic br,
                                       input logic rw, input logic j, input logic js,
                                       input logic az, input logic [2:0] ms,
                                       input logic [1:0] as, input logic wo, input logic md,
                                       input logic il);
        return {m2r, mw, br, rw, j, js, az, ms, as, wo, md, il};
    endfunction

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_LW    = 32'h00402083;
    localparam logic [31:0] I_SW    = 32'h00102423;
    localparam logic [31:0] I_JALR  = 32'h000100E7;
    localparam logic [31:0] I_BEQ   = 32'h00208063;
    localparam logic [31:0] I_ECALL = 32'h00000073;
    localparam logic [31:0] I_MUL   = 32'h022081B3;
    localparam logic [31:0] I_ADDW  = 32'h002081BB;
    localparam logic [31:0] I_LD    = 32'h00003083;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic [14:0] obs, input logic [14:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change here, checks follow a short settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        logic [31:0] stream [4];
        logic [14:0] expb [4];
        stream[0] = I_ADD;  expb[0] = bv(0, 0, 0, 1, 0, 0, 0, 3'b000, 2'd0, 0, 0, 0);
        stream[1] = I_LW;   expb[1] = bv(1, 0, 0, 1, 0, 0, 0, 3'b010, 2'd1, 0, 0, 0);
        stream[2] = I_SW;   expb[2] = bv(0, 1, 0, 0, 0, 0, 0, 3'b010, 2'd1, 0, 0, 0);
        stream[3] = I_JALR; expb[3] = bv(0, 0, 0, 1, 1, 1, 1, 3'b000, 2'd3, 0, 0, 0);

        rst_n = 1'b0;  bus32.in_valid = 1'b1; bus32.instr = I_ADD;
        bus32.flush = 1'b0; bus32.out_ready = 1'b1;
        rst64_n = 1'b0; bus64.in_valid = 1'b0; bus64.instr = I_ADDW;
        bus64.flush = 1'b0; bus64.out_ready = 1'b1;

        // Reset held for two cycles with in_valid high
        tick(); tick(); settle();
        chk1("rst_out_valid", bus32.out_valid, 1'b0);
        chk1("rst_hlt", bus32.hlt, 1'b0);
        chkb("rst_bundle", obs32, '0);

        // Back-to-back stream: each bundle appears one edge after its accept
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus32.instr = stream[i];
            settle();
            chk1("stream_in_ready", bus32.in_ready, 1'b1);
            tick();
            if (i == 3) bus32.in_valid = 1'b0;
            settle();
            chk1("stream_out_valid", bus32.out_valid, 1'b1);
            chkb("stream_bundle", obs32, expb[i]);
        end
        tick(); settle();
        chk1("drain_out_valid", bus32.out_valid, 1'b0);

        // Stall: beq held while EX is not ready
        bus32.in_valid = 1'b1; bus32.instr = I_BEQ;
        tick();
        bus32.out_ready = 1'b0; bus32.instr = I_ADD;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk1("stall_in_ready", bus32.in_ready, 1'b0);
            chk1("stall_out_valid", bus32.out_valid, 1'b1);
            chkb("stall_bundle", obs32, bv(0, 0, 1, 0, 0, 0, 0, 3'b000, 2'd0, 0, 0, 0));
            tick();
        end
        bus32.out_ready = 1'b1;
        settle();
        chk1("unstall_in_ready", bus32.in_ready, 1'b1);
        tick(); settle();
        chkb("unstall_bundle", obs32, expb[0]);
        chk1("unstall_out_valid", bus32.out_valid, 1'b1);

        // Flush squashes the held bundle and blocks the offered instruction
        bus32.flush = 1'b1; bus32.instr = I_LW;
        settle();
        chk1("flush_in_ready", bus32.in_ready, 1'b0);
        tick();
        bus32.flush = 1'b0; bus32.in_valid = 1'b0;
        settle();
        chk1("flush_out_valid", bus32.out_valid, 1'b0);
        tick(); settle();
        chk1("flush_not_accepted", bus32.out_valid, 1'b0);

        // M extension
        bus32.in_valid = 1'b1; bus32.instr = I_MUL;
        tick();
        bus32.in_valid = 1'b0;
        settle();
        chkb("mul_bundle", obs32, bv(0, 0, 0, 1, 0, 0, 0, 3'b000, 2'd0, 0, 1, 0));
        tick();

        // ecall squashed by a flush while draining -> back to RUN, never halts
        bus32.out_ready = 1'b0; bus32.in_valid = 1'b1; bus32.instr = I_ECALL;
        tick();
        bus32.instr = I_ADD;
        settle();
        chkb("ecall_bundle", obs32, '0);
        chk1("drain_in_ready", bus32.in_ready, 1'b0);
        bus32.flush = 1'b1;
        tick();
        bus32.flush = 1'b0; bus32.in_valid = 1'b0; bus32.out_ready = 1'b1;
        repeat (5) tick();
        settle();
        chk1("flushdrain_hlt", bus32.hlt, 1'b0);
        chk1("flushdrain_in_ready", bus32.in_ready, 1'b1);
        chk1("flushdrain_out_valid", bus32.out_valid, 1'b0);

        // ecall: countdown starts only once consumed, hlt exactly 3 cycles after
        bus32.out_ready = 1'b0; bus32.in_valid = 1'b1; bus32.instr = I_ECALL;
        tick();
        bus32.in_valid = 1'b0;
        tick(); tick(); settle();
        chk1("ecall_held_valid", bus32.out_valid, 1'b1);
        chk1("ecall_held_hlt", bus32.hlt, 1'b0);
        bus32.out_ready = 1'b1;
        tick(); settle();
        chk1("ecall_consumed", bus32.out_valid, 1'b0);
        tick(); settle();
        chk1("ecall_hlt_c1", bus32.hlt, 1'b0);
        tick(); settle();
        chk1("ecall_hlt_c2", bus32.hlt, 1'b0);
        tick(); settle();
        chk1("ecall_hlt_c3", bus32.hlt, 1'b1);
        bus32.in_valid = 1'b1; bus32.instr = I_ADD;
        repeat (3) tick();
        settle();
        chk1("halted_in_ready", bus32.in_ready, 1'b0);
        chk1("halted_out_valid", bus32.out_valid, 1'b0);
        chk1("halted_sticky", bus32.hlt, 1'b1);

        // Reset while halted
        bus32.in_valid = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
        chk1("rehalt_rst_hlt", bus32.hlt, 1'b0);
        chk1("rehalt_rst_in_ready", bus32.in_ready, 1'b1);
        chkb("rehalt_rst_bundle", obs32, '0);

        // XLEN=32: OP-32 opcode is illegal and halts
        bus32.in_valid = 1'b1; bus32.instr = I_ADDW;
        tick();
        bus32.in_valid = 1'b0;
        settle();
        chkb("ill32_bundle", obs32, bv(0, 0, 0, 0, 0, 0, 0, 3'b000, 2'd0, 0, 0, 1));
        chk1("ill32_in_ready", bus32.in_ready, 1'b0);
        repeat (3) tick();
        settle();
        chk1("ill32_hlt_early", bus32.hlt, 1'b0);
        tick(); settle();
        chk1("ill32_hlt", bus32.hlt, 1'b1);

        // XLEN=64 instance: addw and ld are legal
        rst64_n = 1'b1; bus64.in_valid = 1'b1; bus64.instr = I_ADDW;
        tick();
        bus64.instr = I_LD;
        settle();
        chkb("addw64_bundle", obs64, bv(0, 0, 0, 1, 0, 0, 0, 3'b000, 2'd0, 1, 0, 0));
        tick();
        bus64.in_valid = 1'b0;
        settle();
        chkb("ld64_bundle", obs64, bv(1, 0, 0, 1, 0, 0, 0, 3'b011, 2'd1, 0, 0, 0));
        chk1("ld64_in_ready", bus64.in_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
